// File: rtl/cmac_tx_arb_pkg.sv
// Shared types and constants for the CMAC TX AXIS packet arbiter.
package cmac_tx_arb_pkg;

    localparam int DATA_W = 512;
    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PKT  = 1'b1
    } state_e;

    // Index width for a source count; never below 1 so a grant register always exists.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/cmac_tx_axis_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo NUM_SRC.
module rr_pick
    import cmac_tx_arb_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int IDX_W   = clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   gnt
);

    logic [NUM_SRC-1:0] gnt_oh;
    logic               found;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path infers a latch.
        gnt_oh = '0;
        found  = 1'b0;
        for (int off = 1; off <= NUM_SRC; off++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!found && req[i] && (i == (int'(last) + off) % NUM_SRC)) begin
                    gnt_oh[i] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt = last;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt_oh[i]) begin
                gnt = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cmac_tx_axis_arbiter.sv
// Packet-locked round-robin arbiter feeding the CMAC TX AXIS port.
// Optional per-source packet counters: define CMAC_TX_ARB_PKT_CNT_EN.
module cmac_tx_axis_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int DATA_W  = cmac_tx_arb_pkg::DATA_W,
    parameter int KEEP_W  = DATA_W / 8
) (
    input  logic                                        aclk,
    input  logic                                        aresetn,
    input  logic                                        arb_en,
    input  logic [NUM_SRC-1:0]                          s_axis_tvalid,
    output logic [NUM_SRC-1:0]                          s_axis_tready,
    input  logic [NUM_SRC*DATA_W-1:0]                   s_axis_tdata,
    input  logic [NUM_SRC*KEEP_W-1:0]                   s_axis_tkeep,
    input  logic [NUM_SRC-1:0]                          s_axis_tlast,
    input  logic [NUM_SRC-1:0]                          s_axis_tuser,
    output logic                                        m_axis_tvalid,
    input  logic                                        m_axis_tready,
    output logic [DATA_W-1:0]                           m_axis_tdata,
    output logic [KEEP_W-1:0]                           m_axis_tkeep,
    output logic                                        m_axis_tlast,
    output logic                                        m_axis_tuser,
    output logic [cmac_tx_arb_pkg::clog2(NUM_SRC)-1:0]  grant_id,
    output logic                                        arb_busy,
    output logic [NUM_SRC*32-1:0]                       pkt_cnt
);

    import cmac_tx_arb_pkg::state_e;
    import cmac_tx_arb_pkg::S_IDLE;
    import cmac_tx_arb_pkg::S_PKT;

    localparam int GW = cmac_tx_arb_pkg::clog2(NUM_SRC);

    state_e         state_q, state_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [GW-1:0]  pick;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (GW)
    ) u_rr_pick (
        .req  (s_axis_tvalid),
        .last (grant_q),
        .gnt  (pick)
    );

    // Reset grant points at the last source so src0 wins the first tie.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            grant_q <= GW'(NUM_SRC - 1);
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arb_en && (|s_axis_tvalid)) begin
                    grant_d = pick;
                    state_d = S_PKT;
                end
            end
            S_PKT: begin
                // Zero-latency pass-through of the locked source; grant holds until tlast is taken.
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (grant_q == GW'(i)) begin
                        m_axis_tvalid    = s_axis_tvalid[i];
                        m_axis_tdata     = s_axis_tdata[i*DATA_W +: DATA_W];
                        m_axis_tkeep     = s_axis_tkeep[i*KEEP_W +: KEEP_W];
                        m_axis_tlast     = s_axis_tlast[i];
                        m_axis_tuser     = s_axis_tuser[i];
                        s_axis_tready[i] = m_axis_tready;
                    end
                end
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign grant_id = grant_q;
    assign arb_busy = (state_q == S_PKT);

`ifdef CMAC_TX_ARB_PKT_CNT_EN
    logic        cnt_inc;
    logic [31:0] cnt_q [NUM_SRC];

    assign cnt_inc = arb_busy & m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // Counters wrap modulo 2^32 by design.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (cnt_inc) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant_q == GW'(i)) begin
                    cnt_q[i] <= cnt_q[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        pkt_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pkt_cnt[i*32 +: 32] = cnt_q[i];
        end
    end
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_cmac_tx_axis_arbiter.sv
// Directed bench for cmac_tx_axis_arbiter (NUM_SRC=2); counter expectations follow CMAC_TX_ARB_PKT_CNT_EN.
module tb_cmac_tx_axis_arbiter;

`ifdef CMAC_TX_ARB_PKT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          arb_en;
    logic [1:0]    s_axis_tvalid;
    logic [1:0]    s_axis_tready;
    logic [1023:0] s_axis_tdata;
    logic [127:0]  s_axis_tkeep;
    logic [1:0]    s_axis_tlast;
    logic [1:0]    s_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [511:0]  m_axis_tdata;
    logic [63:0]   m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic [0:0]    grant_id;
    logic          arb_busy;
    logic [63:0]   pkt_cnt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] tag [2];

    always #5 aclk = ~aclk;

    cmac_tx_axis_arbiter #(
        .NUM_SRC (2),
        .DATA_W  (512),
        .KEEP_W  (64)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .arb_en        (arb_en),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .grant_id      (grant_id),
        .arb_busy      (arb_busy),
        .pkt_cnt       (pkt_cnt)
    );

    typedef struct {
        logic       en;
        logic [1:0] tv;
        logic [1:0] tl;
        logic       mr;
        logic       e_valid;
        logic       e_last;
        logic [1:0] e_ready;
        logic       e_gnt;
        logic       e_busy;
        int         e_src;
    } vec_t;

    vec_t vecs [22];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Called just after a falling edge; leaves 1 time unit for the outputs to settle.
    task automatic drive(input logic en, input logic [1:0] tv, input logic [1:0] tl, input logic mr);
        arb_en        = en;
        s_axis_tvalid = tv;
        s_axis_tlast  = tl;
        m_axis_tready = mr;
        for (int i = 0; i < 2; i++) begin
            s_axis_tdata[i*512 +: 512] = {16{tag[i]}};
            s_axis_tkeep[i*64 +: 64]   = {2{tag[i]}};
            s_axis_tuser[i]            = tag[i][0];
        end
        #1;
    endtask

    initial begin
        int cyc, acc, pkts, bad, beat, p, leak, gbad, hold_bad;
        bit done;
        logic en, mr;
        logic [31:0] exp_tag;
        logic [511:0] exp_data;
        logic [63:0]  exp_keep;
        logic         exp_user;

        //            en    tv     tl     mr    val   last  rdy    gnt   busy  src
        vecs[0]  = '{1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, -1};
        vecs[1]  = '{1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1,  0};
        vecs[2]  = '{1'b1, 2'b11, 2'b01, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1,  0};
        vecs[3]  = '{1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, -1};
        vecs[4]  = '{1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1,  1};
        vecs[5]  = '{1'b1, 2'b11, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1,  1};
        vecs[6]  = '{1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, -1};
        vecs[7]  = '{1'b1, 2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1,  0};
        vecs[8]  = '{1'b1, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1,  0};
        vecs[9]  = '{1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, -1};
        vecs[10] = '{1'b1, 2'b11, 2'b01, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1,  1};
        vecs[11] = '{1'b1, 2'b11, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1,  1};
        vecs[12] = '{1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, -1};
        vecs[13] = '{1'b1, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1,  1};
        vecs[14] = '{1'b1, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1,  1};
        vecs[15] = '{1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, -1};
        vecs[16] = '{1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, -1};
        vecs[17] = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, -1};
        vecs[18] = '{1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, -1};
        vecs[19] = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1,  0};
        vecs[20] = '{1'b1, 2'b01, 2'b01, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1,  0};
        vecs[21] = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, -1};

        // Reset state, with sources already pushing traffic.
        aresetn = 1'b0;
        tag[0]  = 32'h1111_1111;
        tag[1]  = 32'h2222_2222;
        drive(1'b1, 2'b11, 2'b11, 1'b1);
        repeat (2) @(negedge aclk);
        #1;
        check("rst s_tready", s_axis_tready, 2'b00);
        check("rst m_tvalid", m_axis_tvalid, 1'b0);
        check("rst m_tdata", m_axis_tdata, '0);
        check("rst grant_id", grant_id, 1'b1);
        check("rst arb_busy", arb_busy, 1'b0);
        check("rst pkt_cnt", pkt_cnt, 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        // Vector table: alternation, tlast lock, stalls, arb_en gating, valid drop.
        for (int k = 0; k < 22; k++) begin
            tag[0] = 32'hA000_0000 + k;
            tag[1] = 32'hB000_0000 + k;
            drive(vecs[k].en, vecs[k].tv, vecs[k].tl, vecs[k].mr);
            exp_data = '0;
            exp_keep = '0;
            exp_user = 1'b0;
            if (vecs[k].e_src >= 0) begin
                exp_tag  = tag[vecs[k].e_src];
                exp_data = {16{exp_tag}};
                exp_keep = {2{exp_tag}};
                exp_user = exp_tag[0];
            end
            check($sformatf("v%0d m_tvalid", k), m_axis_tvalid, vecs[k].e_valid);
            check($sformatf("v%0d m_tlast", k), m_axis_tlast, vecs[k].e_last);
            check($sformatf("v%0d s_tready", k), s_axis_tready, vecs[k].e_ready);
            check($sformatf("v%0d grant_id", k), grant_id, vecs[k].e_gnt);
            check($sformatf("v%0d arb_busy", k), arb_busy, vecs[k].e_busy);
            check($sformatf("v%0d m_tdata", k), m_axis_tdata, exp_data);
            check($sformatf("v%0d m_tkeep", k), m_axis_tkeep, exp_keep);
            check($sformatf("v%0d m_tuser", k), m_axis_tuser, exp_user);
            @(negedge aclk);
        end
        check("table pkt_cnt", pkt_cnt, CNT_ON ? {32'd3, 32'd3} : 64'd0);

        // Reset pulse between tests restores counters and grant pointer.
        aresetn = 1'b0;
        drive(1'b1, 2'b00, 2'b00, 1'b1);
        @(negedge aclk);
        check("pulse pkt_cnt", pkt_cnt, 64'd0);
        check("pulse grant_id", grant_id, 1'b1);
        aresetn = 1'b1;

        // src0 alone: 3 packets of 9 beats, one bubble per packet -> 30 cycles.
        cyc = 0; acc = 0; pkts = 0; bad = 0; beat = 0; p = 0;
        while (pkts < 3 && cyc < 200) begin
            tag[0] = 32'hC000_0000 + p * 256 + beat;
            drive(1'b1, 2'b01, {1'b0, beat == 8}, 1'b1);
            cyc++;
            if (m_axis_tvalid && m_axis_tready) begin
                acc++;
                exp_tag = tag[0];
                if (m_axis_tdata !== {16{exp_tag}}) bad++;
                if (m_axis_tlast) pkts++;
            end
            if (s_axis_tready[0]) begin
                if (beat == 8) begin
                    beat = 0;
                    p++;
                end else begin
                    beat++;
                end
            end
            @(negedge aclk);
        end
        check("t1 cycles", cyc, 30);
        check("t1 beats", acc, 27);
        check("t1 data errors", bad, 0);
        check("t1 pkt_cnt", pkt_cnt, CNT_ON ? {32'd0, 32'd3} : 64'd0);
        drive(1'b1, 2'b00, 2'b00, 1'b1);

        // src1 packet under tready 1,0,1,0 while src0 also requests.
        cyc = 0; acc = 0; bad = 0; beat = 0; leak = 0; gbad = 0; done = 1'b0;
        while (!done && cyc < 60) begin
            tag[0] = 32'hEEEE_0000;
            tag[1] = 32'hD000_0000 + beat;
            mr = (cyc % 2 == 0);
            drive(1'b1, 2'b11, {beat == 3, 1'b0}, mr);
            if (s_axis_tready[0]) leak++;
            if (arb_busy && grant_id !== 1'b1) gbad++;
            if (m_axis_tvalid && m_axis_tready) begin
                exp_tag = 32'hD000_0000 + acc;
                if (m_axis_tdata !== {16{exp_tag}}) bad++;
                acc++;
                if (m_axis_tlast) done = 1'b1;
            end
            if (s_axis_tready[1]) beat++;
            cyc++;
            @(negedge aclk);
        end
        check("t3 beats", acc, 4);
        check("t3 cycles", cyc, 9);
        check("t3 data errors", bad, 0);
        check("t3 src0 tready leaks", leak, 0);
        check("t3 grant errors", gbad, 0);
        drive(1'b1, 2'b00, 2'b00, 1'b1);

        // arb_en drops on beat 2 of a 5-beat src0 packet.
        cyc = 0; acc = 0; beat = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            en = (beat < 2);
            tag[0] = 32'hF000_0000 + beat;
            drive(en, 2'b01, {1'b0, beat == 4}, 1'b1);
            if (m_axis_tvalid && m_axis_tready) begin
                acc++;
                if (m_axis_tlast) done = 1'b1;
            end
            if (s_axis_tready[0]) beat++;
            cyc++;
            @(negedge aclk);
        end
        check("t4 beats", acc, 5);
        check("t4 cycles", cyc, 6);
        hold_bad = 0;
        tag[0] = 32'hF100_0000;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 2'b01, 2'b00, 1'b1);
            if (arb_busy || m_axis_tvalid) hold_bad++;
            @(negedge aclk);
        end
        check("t4 held while disabled", hold_bad, 0);
        drive(1'b1, 2'b01, 2'b00, 1'b1);
        check("t4 enable cycle busy", arb_busy, 1'b0);
        @(negedge aclk);
        drive(1'b1, 2'b01, 2'b00, 1'b1);
        check("t4 resumed busy", arb_busy, 1'b1);
        check("t4 resumed grant", grant_id, 1'b0);
        check("t4 resumed m_tvalid", m_axis_tvalid, 1'b1);
        check("t4 pkt_cnt", pkt_cnt, CNT_ON ? {32'd1, 32'd4} : 64'd0);
        @(negedge aclk);

        // Reset in the middle of the resumed packet.
        drive(1'b1, 2'b01, 2'b00, 1'b1);
        #2;
        aresetn = 1'b0;
        #1;
        check("t5 async m_tvalid", m_axis_tvalid, 1'b0);
        @(negedge aclk);
        #1;
        check("t5 m_tvalid", m_axis_tvalid, 1'b0);
        check("t5 grant_id", grant_id, 1'b1);
        check("t5 pkt_cnt", pkt_cnt, 64'd0);
        check("t5 arb_busy", arb_busy, 1'b0);
        check("t5 s_tready", s_axis_tready, 2'b00);
        @(negedge aclk);
        aresetn = 1'b1;
        drive(1'b1, 2'b00, 2'b00, 1'b1);
        @(negedge aclk);
        #1;
        check("t5 idle after release", arb_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
